cluster_pwr_seq: RTL

Power/boot sequencer for the cluster port of the SoC domain. It drives the cluster power, isolation (`byp`), clock-enable, reset and fetch-enable lines in a fixed, counted order. On power-down it waits for the cluster to go idle before removing power. It sits in the SoC domain, is commanded by a single-entry valid/ready request from the APB-facing control registers, and reports state and completion back to them.

---
 rtl/cluster_pwr_pkg.sv | 50 +++++
 rtl/cluster_pwr_cnt.sv | 32 +++
 rtl/cluster_pwr_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cluster_pwr_pkg.sv
// cluster_pwr_pkg
// Shared types for the cluster power sequencer:
//   cluster_pwr_state_e - sequencer state, also reported on status_o
//   cluster_pwr_out_t   - the five cluster control lines driven per state
//   state_outputs()     - state -> control-line decode
package cluster_pwr_pkg;

  typedef enum logic [3:0] {
    ST_OFF     = 4'd0,
    ST_PWR_UP  = 4'd1,
    ST_ISO_OFF = 4'd2,
    ST_CLK_ON  = 4'd3,
    ST_RST_REL = 4'd4,
    ST_RUN     = 4'd5,
    ST_DRAIN   = 4'd6,
    ST_ISO_ON  = 4'd7,
    ST_PWR_DN  = 4'd8
  } cluster_pwr_state_e;

  typedef struct packed {
    logic pow;
    logic byp;
    logic clk_en;
    logic rstn;
    logic fetch_en;
  } cluster_pwr_out_t;

  // Powered-down cluster: switch open, isolation clamped, everything else low.
  localparam cluster_pwr_out_t OUT_RESET = '{pow: 1'b0, byp: 1'b1, clk_en: 1'b0,
                                             rstn: 1'b0, fetch_en: 1'b0};

  function automatic cluster_pwr_out_t state_outputs(input cluster_pwr_state_e s);
    cluster_pwr_out_t o;
    o = OUT_RESET;
    case (s)
      ST_PWR_UP:  o.pow = 1'b1;
      ST_ISO_OFF: begin o.pow = 1'b1; o.byp = 1'b0; end
      ST_CLK_ON:  begin o.pow = 1'b1; o.byp = 1'b0; o.clk_en = 1'b1; end
      ST_RST_REL,
      ST_DRAIN:   begin o.pow = 1'b1; o.byp = 1'b0; o.clk_en = 1'b1; o.rstn = 1'b1; end
      ST_RUN:     begin
        o.pow = 1'b1; o.byp = 1'b0; o.clk_en = 1'b1; o.rstn = 1'b1; o.fetch_en = 1'b1;
      end
      ST_ISO_ON:  o.pow = 1'b1;
      default:    o = OUT_RESET;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cluster_pwr_cnt.sv
// cluster_pwr_cnt
// Loadable down-counter that stops at zero (never wraps).
//   clk_i, rst_i  clock, asynchronous active-high reset
//   load_i        load load_val_i this cycle (takes priority over counting)
//   load_val_i    value to load
//   zero_o        count is zero
module cluster_pwr_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)            cnt_d = load_val_i;
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// cluster_pwr_seq
// Power/boot sequencer for the cluster. Walks power, isolation, clock,
// reset and fetch-enable through a counted on/off sequence, waiting for the
// cluster to go idle (with optional timeout) before powering down.
//   clk_i, rst_i            clock, asynchronous active-high reset
//   cmd_valid_i/cmd_on_i    single-entry command (1 = on, 0 = off)
//   cmd_ready_o             high only in OFF and RUN
//   boot_addr_i             boot address, latched on accepted on-command in OFF
//   cluster_busy_i          cluster activity, polled in DRAIN
//   cluster_*_o             registered cluster control lines
//   status_o                current state encoding
//   done_o                  one-cycle pulse on reaching RUN/OFF or redundant command
//   timeout_o               sticky drain-timeout flag, cleared by next accepted command
module cluster_pwr_seq
  import cluster_pwr_pkg::*;
#(
  parameter int PWR_CYCLES    = 32,
  parameter int ISO_CYCLES    = 4,
  parameter int RST_CYCLES    = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  input  logic        cmd_on_i,
  output logic        cmd_ready_o,
  input  logic [63:0] boot_addr_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic [3:0]  status_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int MAX_PI  = (PWR_CYCLES > ISO_CYCLES) ? PWR_CYCLES : ISO_CYCLES;
  localparam int MAX_PIR = (MAX_PI > RST_CYCLES) ? MAX_PI : RST_CYCLES;
  localparam int CNT_MAX = (MAX_PIR > DRAIN_TIMEOUT) ? MAX_PIR : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  cluster_pwr_state_e state_q, state_d;
  cluster_pwr_out_t   out_q, out_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [63:0]        boot_q, boot_d;

  logic               cmd_acc;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_zero;

  // Counted states load N-1 so they last exactly N cycles. DRAIN loads the
  // full timeout so the timeout fires after DRAIN_TIMEOUT busy samples.
  function automatic logic [CNT_W-1:0] entry_count(input cluster_pwr_state_e s);
    case (s)
      ST_PWR_UP, ST_PWR_DN: return CNT_W'(PWR_CYCLES - 1);
      ST_ISO_OFF, ST_ISO_ON: return CNT_W'(ISO_CYCLES - 1);
      ST_CLK_ON:            return CNT_W'(RST_CYCLES - 1);
      ST_DRAIN:             return CNT_W'(DRAIN_TIMEOUT);
      default:              return '0;
    endcase
  endfunction

  assign cmd_acc = cmd_valid_i && ready_q;

  always_comb begin
    state_d   = state_q;
    boot_d    = boot_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    if (cmd_acc) timeout_d = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (cmd_acc) begin
          if (cmd_on_i) begin
            state_d = ST_PWR_UP;
            boot_d  = boot_addr_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_PWR_UP:  if (cnt_zero) state_d = ST_ISO_OFF;
      ST_ISO_OFF: if (cnt_zero) state_d = ST_CLK_ON;
      ST_CLK_ON:  if (cnt_zero) state_d = ST_RST_REL;
      ST_RST_REL: state_d = ST_RUN;
      ST_RUN: begin
        if (cmd_acc) begin
          if (!cmd_on_i) state_d = ST_DRAIN;
          else           done_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        // An idle sample wins over a simultaneous timeout.
        if (!cluster_busy_i) begin
          state_d = ST_ISO_ON;
        end else if (DRAIN_TIMEOUT != 0 && cnt_zero) begin
          state_d   = ST_ISO_ON;
          timeout_d = 1'b1;
        end
      end
      ST_ISO_ON:  if (cnt_zero) state_d = ST_PWR_DN;
      ST_PWR_DN:  if (cnt_zero) state_d = ST_OFF;
      default:    state_d = ST_OFF;
    endcase

    if (state_d != state_q && (state_d == ST_RUN || state_d == ST_OFF)) done_d = 1'b1;

    // Outputs are registered from the next state so they change with the state.
    out_d        = state_outputs(state_d);
    ready_d      = (state_d == ST_OFF) || (state_d == ST_RUN);
    cnt_load     = (state_d != state_q);
    cnt_load_val = entry_count(state_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      out_q     <= OUT_RESET;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      boot_q    <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      boot_q    <= boot_d;
    end
  end

  cluster_pwr_cnt #(.W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  assign cmd_ready_o            = ready_q;
  assign cluster_pow_o          = out_q.pow;
  assign cluster_byp_o          = out_q.byp;
  assign cluster_clk_en_o       = out_q.clk_en;
  assign cluster_rstn_o         = out_q.rstn;
  assign cluster_fetch_enable_o = out_q.fetch_en;
  assign cluster_boot_addr_o    = boot_q;
  assign status_o               = state_q;
  assign done_o                 = done_q;
  assign timeout_o              = timeout_q;

endmodule
